// File: rtl/triangle_meas.sv
// Triangle-wave measurement: hysteresis peak/valley detection with rise, fall,
// period and amplitude reporting once per waveform cycle.
module triangle_meas #(
  parameter int              DW      = 14,
  parameter int              CW      = 32,
  parameter int              HYST    = 16,
  parameter int              TIMEOUT = 1 << 20,
  parameter logic [CW-1:0]   T_INIT  = '0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] vmax,
  output logic signed [DW-1:0] vmin,
  output logic        [DW:0]   vpp,
  output logic        [CW-1:0] rise_len,
  output logic        [CW-1:0] fall_len,
  output logic        [CW-1:0] period,
  output logic                 meas_valid,
  output logic                 locked
);

  typedef enum logic [1:0] {ACQ = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;

  localparam logic signed [DW+1:0] HYST_X    = (DW+2)'(HYST);
  localparam logic        [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);

  // Two guard bits keep extremum +/- HYST exact at full scale.
  function automatic logic signed [DW+1:0] sx(input logic signed [DW-1:0] x);
    return {{2{x[DW-1]}}, x};
  endfunction

  function automatic logic above(input logic signed [DW-1:0] x,
                                 input logic signed [DW-1:0] base);
    return sx(x) > (sx(base) + HYST_X);
  endfunction

  function automatic logic below(input logic signed [DW-1:0] x,
                                 input logic signed [DW-1:0] base);
    return sx(x) < (sx(base) - HYST_X);
  endfunction

  function automatic logic [DW:0] span(input logic signed [DW-1:0] hi,
                                       input logic signed [DW-1:0] lo);
    return {hi[DW-1], hi} - {lo[DW-1], lo};
  endfunction

  state_t                 state;
  logic                   acq_first;
  logic                   have_peak;
  logic        [CW-1:0]   t;
  logic        [CW-1:0]   idle;
  logic        [CW-1:0]   t_max;
  logic        [CW-1:0]   t_min;
  logic        [CW-1:0]   t_pk;
  logic        [CW-1:0]   t_val;
  logic        [CW-1:0]   t_pk_prev;
  logic signed [DW-1:0]   run_max;
  logic signed [DW-1:0]   run_min;
  logic signed [DW-1:0]   pk;
  logic signed [DW-1:0]   val;
  logic                   turn;
  logic                   timeout;

  always_comb begin
    turn = 1'b0;
    case (state)
      ACQ:     turn = !acq_first && (above(din, run_min) || below(din, run_max));
      RISE:    turn = below(din, pk);
      FALL:    turn = above(din, val);
      default: turn = 1'b0;
    endcase
    // A turn on the same sample as the timeout takes priority.
    timeout = !turn && (idle == IDLE_LAST);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ACQ;
      acq_first  <= 1'b1;
      have_peak  <= 1'b0;
      t          <= T_INIT;
      idle       <= '0;
      t_max      <= '0;
      t_min      <= '0;
      t_pk       <= '0;
      t_val      <= '0;
      t_pk_prev  <= '0;
      run_max    <= '0;
      run_min    <= '0;
      pk         <= '0;
      val        <= '0;
      vmax       <= '0;
      vmin       <= '0;
      vpp        <= '0;
      rise_len   <= '0;
      fall_len   <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (en) begin
        t <= t + CW'(1);
        if (turn || timeout) idle <= '0;
        else                 idle <= idle + CW'(1);

        if (timeout) begin
          state     <= ACQ;
          acq_first <= 1'b1;
          have_peak <= 1'b0;
          locked    <= 1'b0;
        end else begin
          case (state)
            ACQ: begin
              if (acq_first) begin
                acq_first <= 1'b0;
                run_max   <= din;
                run_min   <= din;
                t_max     <= t;
                t_min     <= t;
              end else begin
                if (din > run_max) begin
                  run_max <= din;
                  t_max   <= t;
                end
                if (din < run_min) begin
                  run_min <= din;
                  t_min   <= t;
                end
                if (above(din, run_min)) begin
                  val   <= run_min;
                  t_val <= t_min;
                  pk    <= din;
                  t_pk  <= t;
                  state <= RISE;
                end else if (below(din, run_max)) begin
                  // The acquired maximum counts as the first detected peak.
                  t_pk_prev <= t_max;
                  have_peak <= 1'b1;
                  val       <= din;
                  t_val     <= t;
                  state     <= FALL;
                end
              end
            end
            RISE: begin
              if (turn) begin
                if (have_peak) begin
                  rise_len   <= t_pk - t_val;
                  fall_len   <= t_val - t_pk_prev;
                  period     <= t_pk - t_pk_prev;
                  vmax       <= pk;
                  vmin       <= val;
                  vpp        <= span(pk, val);
                  meas_valid <= 1'b1;
                  locked     <= 1'b1;
                end
                t_pk_prev <= t_pk;
                have_peak <= 1'b1;
                val       <= din;
                t_val     <= t;
                state     <= FALL;
              end else if (din > pk) begin
                pk   <= din;
                t_pk <= t;
              end
            end
            FALL: begin
              if (turn) begin
                pk    <= din;
                t_pk  <= t;
                state <= RISE;
              end else if (din < val) begin
                val   <= din;
                t_val <= t;
              end
            end
            default: state <= ACQ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_triangle_meas.sv
// Bench for triangle_meas: table of waveform scenarios plus hand-written
// timeout and asynchronous-reset sequences. Index counter starts near wrap.
module tb_triangle_meas;

  localparam int DW      = 14;
  localparam int CW      = 32;
  localparam int HYST    = 16;
  localparam int TIMEOUT = 300;
  localparam logic [CW-1:0] T_INIT = 32'hFFFF_FFCE;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 en = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic signed [DW-1:0] vmax;
  logic signed [DW-1:0] vmin;
  logic        [DW:0]   vpp;
  logic        [CW-1:0] rise_len;
  logic        [CW-1:0] fall_len;
  logic        [CW-1:0] period;
  logic                 meas_valid;
  logic                 locked;

  triangle_meas #(.DW(DW), .CW(CW), .HYST(HYST), .TIMEOUT(TIMEOUT), .T_INIT(T_INIT)) dut (
    .clk(clk), .rstn(rstn), .en(en), .din(din),
    .vmax(vmax), .vmin(vmin), .vpp(vpp),
    .rise_len(rise_len), .fall_len(fall_len), .period(period),
    .meas_valid(meas_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    string name;
    int    up, dn, lo, hi;
    bit    noise, en_alt;
    int    nsamp;
    int    rise, fall, per, vmx, vmn, vp;
    int    first, space, ltol, vtol, cnt;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input longint act, input longint exp, input longint tol);
    total++;
    if ((act - exp > tol) || (exp - act > tol)) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  function automatic int wv(input int n, input int up, input int dn, input int lo, input int hi);
    int p;
    p = n % (up + dn);
    if (p <= up) return lo + ((hi - lo) * p) / up;
    return hi - ((hi - lo) * (p - up)) / dn;
  endfunction

  task automatic step(input bit e, input int v);
    en  = e;
    din = DW'(v);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    en   = 1'b0;
    din  = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vmax"}, vmax, 0, 0);
    chk({tag, "_vmin"}, vmin, 0, 0);
    chk({tag, "_vpp"}, vpp, 0, 0);
    chk({tag, "_rise"}, rise_len, 0, 0);
    chk({tag, "_fall"}, fall_len, 0, 0);
    chk({tag, "_period"}, period, 0, 0);
    chk({tag, "_mv"}, meas_valid, 0, 0);
    chk({tag, "_locked"}, locked, 0, 0);
  endtask

  task automatic run_vec(input vec_t r);
    int nmv = 0;
    int last_cyc = 0;
    int v;
    bit lk_early = 0;
    bit mv_idle = 0;
    do_reset();
    for (int n = 0; n < r.nsamp; n++) begin
      v = wv(n, r.up, r.dn, r.lo, r.hi);
      if (r.noise) v = v + int'($urandom_range(16)) - 8;
      step(1'b1, v);
      if (meas_valid) begin
        nmv++;
        if (nmv == 1) begin
          chk({r.name, "_first_idx"}, n, r.first, r.ltol);
          chk({r.name, "_locked_early"}, lk_early, 0, 0);
        end else begin
          chk({r.name, "_spacing"}, cyc - last_cyc, r.space, r.ltol);
        end
        last_cyc = cyc;
        chk({r.name, "_rise"}, rise_len, r.rise, r.ltol);
        chk({r.name, "_fall"}, fall_len, r.fall, r.ltol);
        chk({r.name, "_period"}, period, r.per, r.ltol);
        chk({r.name, "_vmax"}, vmax, r.vmx, r.vtol);
        chk({r.name, "_vmin"}, vmin, r.vmn, r.vtol);
        chk({r.name, "_vpp"}, vpp, r.vp, 2 * r.vtol);
        chk({r.name, "_locked"}, locked, 1, 0);
      end else if (nmv == 0 && locked) begin
        lk_early = 1;
      end
      if (r.en_alt) begin
        step(1'b0, -v);
        if (meas_valid) mv_idle = 1;
      end
    end
    chk({r.name, "_count"}, nmv, r.cnt, 0);
    chk({r.name, "_mv_on_idle"}, mv_idle, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int first_mv;
    int nmv;
    //           name        up  dn   lo     hi   nz alt nsamp rise fall per  vmax  vmin   vpp  first space ltol vtol cnt
    vecs[0] = '{"tri",      100, 60, -4000, 4000, 0, 0,  960, 100, 60, 160, 4000, -4000, 8000,  261, 160, 0, 0, 5};
    vecs[1] = '{"noise",    100, 60, -4000, 4000, 1, 0,  960, 100, 60, 160, 4000, -4000, 8000,  261, 160, 2, 8, 5};
    vecs[2] = '{"fullscale", 50, 50, -8192, 8191, 0, 0,  600,  50, 50, 100, 8191, -8192, 16383, 151, 100, 0, 0, 5};
    vecs[3] = '{"en_alt",   100, 60, -4000, 4000, 0, 1,  960, 100, 60, 160, 4000, -4000, 8000,  261, 320, 0, 0, 5};

    do_reset();
    chk_zero("reset");

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Timeout: constant input after lock, with a frozen stretch of en=0 cycles.
    do_reset();
    for (int n = 0; n <= 261; n++) step(1'b1, wv(n, 100, 60, -4000, 4000));
    chk("to_mv_at_lock", meas_valid, 1, 0);
    c = wv(261, 100, 60, -4000, 4000);
    for (int k = 1; k < TIMEOUT; k++) begin
      step(1'b1, c);
      if (k == 100) repeat (40) step(1'b0, -c);
    end
    chk("to_locked_before", locked, 1, 0);
    step(1'b1, c);
    chk("to_locked_after", locked, 0, 0);
    chk("to_rise_hold", rise_len, 100, 0);
    chk("to_period_hold", period, 160, 0);
    chk("to_vmax_hold", vmax, 4000, 0);
    chk("to_vpp_hold", vpp, 8000, 0);

    // Asynchronous reset mid-cycle, then reacquisition needs two peaks.
    do_reset();
    for (int n = 0; n < 300; n++) step(1'b1, wv(n, 100, 60, -4000, 4000));
    chk("mr_locked_pre", locked, 1, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    rstn = 1'b1;
    first_mv = -1;
    nmv = 0;
    for (int n = 0; n < 300; n++) begin
      step(1'b1, wv(n, 100, 60, -4000, 4000));
      if (n == 260) chk("mr_locked_260", locked, 0, 0);
      if (meas_valid) begin
        nmv++;
        if (first_mv < 0) first_mv = n;
      end
    end
    chk("mr_first_idx", first_mv, 261, 0);
    chk("mr_count", nmv, 1, 0);
    chk("mr_rise", rise_len, 100, 0);
    chk("mr_fall", fall_len, 60, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
